// File: rtl/mcycle_ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcode/funct
// fields, ALU function codes and datapath mux selects.
package mcycle_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_EXEC   = 4'd6,
    ST_ALUWB  = 4'd7,
    ST_BRANCH = 4'd8,
    ST_ADDIEX = 4'd9,
    ST_ADDIWB = 4'd10,
    ST_JUMP   = 4'd11
  } state_e;

  typedef enum logic [1:0] {
    ALU_OP_ADD   = 2'b00,
    ALU_OP_SUB   = 2'b01,
    ALU_OP_FUNCT = 2'b10
  } alu_op_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRC_B_REG     = 2'b00;
  localparam logic [1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] SRC_B_IMM     = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

endpackage

// File: rtl/mcycle_ctrl_if.sv
// Controller <-> datapath bundle. The slave side is the controller; the
// master side is the datapath (or a bench standing in for it).
interface mcycle_ctrl_if;
  logic [5:0] i_opcode;
  logic [5:0] i_funct;
  logic       i_zero;
  logic       i_mem_ready;
  logic [2:0] o_alu_func;
  logic       o_alu_src_a;
  logic [1:0] o_alu_src_b;
  logic [1:0] o_pc_src;
  logic       o_pc_en;
  logic       o_iord;
  logic       o_ir_write;
  logic       o_mem_write;
  logic       o_reg_write;
  logic       o_reg_dst;
  logic       o_mem_to_reg;
  logic       o_illegal;
  logic [3:0] o_state;

  modport slave (
    input  i_opcode, i_funct, i_zero, i_mem_ready,
    output o_alu_func, o_alu_src_a, o_alu_src_b, o_pc_src, o_pc_en, o_iord,
           o_ir_write, o_mem_write, o_reg_write, o_reg_dst, o_mem_to_reg,
           o_illegal, o_state
  );

  modport master (
    output i_opcode, i_funct, i_zero, i_mem_ready,
    input  o_alu_func, o_alu_src_a, o_alu_src_b, o_pc_src, o_pc_en, o_iord,
           o_ir_write, o_mem_write, o_reg_write, o_reg_dst, o_mem_to_reg,
           o_illegal, o_state
  );
endinterface

// File: rtl/mcycle_ctrl_alu_dec.sv
// ALU decoder: maps the FSM's alu_op plus the R-type funct field to the
// ALU function code, flagging funct values it cannot decode.
module alu_dec
  import mcycle_ctrl_pkg::*;
(
  input  alu_op_e    alu_op,
  input  logic [5:0] i_funct,
  output logic [2:0] o_alu_func,
  output logic       o_funct_bad
);

  always_comb begin
    o_alu_func  = ALU_ADD;
    o_funct_bad = 1'b0;
    case (alu_op)
      ALU_OP_ADD: o_alu_func = ALU_ADD;
      ALU_OP_SUB: o_alu_func = ALU_SUB;
      ALU_OP_FUNCT: begin
        case (i_funct)
          FN_ADD:  o_alu_func = ALU_ADD;
          FN_SUB:  o_alu_func = ALU_SUB;
          FN_AND:  o_alu_func = ALU_AND;
          FN_OR:   o_alu_func = ALU_OR;
          FN_SLT:  o_alu_func = ALU_SLT;
          // Unknown funct falls back to ADD so the ALU input stays defined.
          default: o_funct_bad = 1'b1;
        endcase
      end
      default: o_alu_func = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mcycle_ctrl.sv
// Multicycle MIPS-subset control FSM (lw, sw, R-type, beq, addi, j).
// The current state is exported on o_state for debug visibility.
module mcycle_ctrl
  import mcycle_ctrl_pkg::*;
#(
  parameter bit MEM_HS = 1'b1
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  mcycle_ctrl_if.slave  bus
);

  state_e     state, next_state;
  alu_op_e    alu_op;
  logic [2:0] dec_func;
  logic       funct_bad;
  logic       ready;
  logic       alu_en;
  logic       alu_src_a, iord, reg_dst, mem_to_reg;
  logic [1:0] alu_src_b, pc_src;
  logic       pc_en, ir_write, mem_write, reg_write, illegal;

  // i_mem_ready is a completion strobe: a memory state (FETCH, MEMRD, MEMWR)
  // holds its request controls stable every cycle until it samples ready high,
  // and retires in that same cycle.
  assign ready = MEM_HS ? bus.i_mem_ready : 1'b1;

  alu_dec u_alu_dec (
    .alu_op      (alu_op),
    .i_funct     (bus.i_funct),
    .o_alu_func  (dec_func),
    .o_funct_bad (funct_bad)
  );

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= ST_FETCH;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    alu_op     = ALU_OP_ADD;
    alu_en     = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRC_B_REG;
    pc_src     = PC_SRC_ALU;
    pc_en      = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    illegal    = 1'b0;
    case (state)
      ST_FETCH: begin
        alu_en    = 1'b1;
        alu_src_b = SRC_B_FOUR;
        pc_src    = PC_SRC_ALU;
        ir_write  = ready;
        pc_en     = ready;
        if (ready) next_state = ST_DECODE;
      end
      ST_DECODE: begin
        // Branch target is precomputed here while the opcode is decoded.
        alu_en    = 1'b1;
        alu_src_b = SRC_B_IMM_SH2;
        case (bus.i_opcode)
          OP_LW, OP_SW: next_state = ST_MEMADR;
          OP_RTYPE:     next_state = ST_EXEC;
          OP_BEQ:       next_state = ST_BRANCH;
          OP_ADDI:      next_state = ST_ADDIEX;
          OP_J:         next_state = ST_JUMP;
          default: begin
            illegal    = 1'b1;
            next_state = ST_FETCH;
          end
        endcase
      end
      ST_MEMADR: begin
        alu_en     = 1'b1;
        alu_src_a  = 1'b1;
        alu_src_b  = SRC_B_IMM;
        next_state = (bus.i_opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
      end
      ST_MEMRD: begin
        iord = 1'b1;
        if (ready) next_state = ST_MEMWB;
      end
      ST_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        next_state = ST_FETCH;
      end
      ST_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        if (ready) next_state = ST_FETCH;
      end
      ST_EXEC: begin
        alu_en    = 1'b1;
        alu_op    = ALU_OP_FUNCT;
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_REG;
        if (funct_bad) begin
          illegal    = 1'b1;
          next_state = ST_FETCH;
        end else begin
          next_state = ST_ALUWB;
        end
      end
      ST_ALUWB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        next_state = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_en     = 1'b1;
        alu_op     = ALU_OP_SUB;
        alu_src_a  = 1'b1;
        alu_src_b  = SRC_B_REG;
        pc_src     = PC_SRC_ALUOUT;
        pc_en      = bus.i_zero;
        next_state = ST_FETCH;
      end
      ST_ADDIEX: begin
        alu_en     = 1'b1;
        alu_src_a  = 1'b1;
        alu_src_b  = SRC_B_IMM;
        next_state = ST_ADDIWB;
      end
      ST_ADDIWB: begin
        reg_write  = 1'b1;
        next_state = ST_FETCH;
      end
      ST_JUMP: begin
        pc_src     = PC_SRC_JUMP;
        pc_en      = 1'b1;
        next_state = ST_FETCH;
      end
      default: next_state = ST_FETCH;
    endcase
  end

  assign bus.o_alu_func   = alu_en ? dec_func : 3'b000;
  assign bus.o_alu_src_a  = alu_src_a;
  assign bus.o_alu_src_b  = alu_src_b;
  assign bus.o_pc_src     = pc_src;
  assign bus.o_iord       = iord;
  assign bus.o_reg_dst    = reg_dst;
  assign bus.o_mem_to_reg = mem_to_reg;
  assign bus.o_state      = state;

  // Reset also masks the Mealy enables, since FETCH decodes ready directly.
  assign bus.o_pc_en      = pc_en     & i_rstn;
  assign bus.o_ir_write   = ir_write  & i_rstn;
  assign bus.o_mem_write  = mem_write & i_rstn;
  assign bus.o_reg_write  = reg_write & i_rstn;
  assign bus.o_illegal    = illegal   & i_rstn;

endmodule

// File: tb/tb_mcycle_ctrl.sv
// Directed bench for mcycle_ctrl: walks each instruction class through the
// FSM and compares every sampled control against hand-derived values.
module tb_mcycle_ctrl;
  import mcycle_ctrl_pkg::*;

  logic i_clk = 1'b0;
  logic i_rstn;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  mcycle_ctrl_if bus ();

  mcycle_ctrl #(.MEM_HS(1'b1)) dut (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .bus    (bus)
  );

  // Clock / reset block
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sampling happens 2 time units after the rising edge.
  task automatic tick();
    @(posedge i_clk);
    #2;
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                       input logic zero, input logic rdy);
    bus.i_opcode    = op;
    bus.i_funct     = fn;
    bus.i_zero      = zero;
    bus.i_mem_ready = rdy;
    #1;
  endtask

  initial begin
    i_rstn = 1'b0;
    drive(OP_LW, 6'd0, 1'b0, 1'b1);
    repeat (2) @(posedge i_clk);
    #2;
    chk("rst_state",     8'(bus.o_state), 8'd0);
    chk("rst_pc_en",     8'(bus.o_pc_en), 8'd0);
    chk("rst_ir_write",  8'(bus.o_ir_write), 8'd0);
    chk("rst_reg_write", 8'(bus.o_reg_write), 8'd0);
    chk("rst_illegal",   8'(bus.o_illegal), 8'd0);
    i_rstn = 1'b1;
    #1;

    // lw: 0,1,2,3,4,0
    chk("lw_fetch_state",    8'(bus.o_state), 8'd0);
    chk("lw_fetch_ir_write", 8'(bus.o_ir_write), 8'd1);
    chk("lw_fetch_pc_en",    8'(bus.o_pc_en), 8'd1);
    chk("lw_fetch_src_b",    8'(bus.o_alu_src_b), 8'd1);
    chk("lw_fetch_alu_func", 8'(bus.o_alu_func), 8'd2);
    tick();
    chk("lw_decode_state",   8'(bus.o_state), 8'd1);
    chk("lw_decode_src_b",   8'(bus.o_alu_src_b), 8'd3);
    chk("lw_decode_rw",      8'(bus.o_reg_write), 8'd0);
    tick();
    chk("lw_memadr_state",   8'(bus.o_state), 8'd2);
    chk("lw_memadr_src_a",   8'(bus.o_alu_src_a), 8'd1);
    chk("lw_memadr_src_b",   8'(bus.o_alu_src_b), 8'd2);
    tick();
    chk("lw_memrd_state",    8'(bus.o_state), 8'd3);
    chk("lw_memrd_iord",     8'(bus.o_iord), 8'd1);
    chk("lw_memrd_rw",       8'(bus.o_reg_write), 8'd0);
    tick();
    chk("lw_memwb_state",    8'(bus.o_state), 8'd4);
    chk("lw_memwb_rw",       8'(bus.o_reg_write), 8'd1);
    chk("lw_memwb_m2r",      8'(bus.o_mem_to_reg), 8'd1);
    chk("lw_memwb_reg_dst",  8'(bus.o_reg_dst), 8'd0);
    tick();
    chk("lw_done_state",     8'(bus.o_state), 8'd0);

    // FETCH stall with ready low
    drive(OP_RTYPE, FN_SLT, 1'b0, 1'b0);
    chk("stall_ir_write", 8'(bus.o_ir_write), 8'd0);
    chk("stall_pc_en",    8'(bus.o_pc_en), 8'd0);
    tick();
    chk("stall_state",    8'(bus.o_state), 8'd0);

    // R-type slt: 0,1,6,7,0
    drive(OP_RTYPE, FN_SLT, 1'b0, 1'b1);
    tick();
    chk("slt_decode_state", 8'(bus.o_state), 8'd1);
    tick();
    chk("slt_exec_state",   8'(bus.o_state), 8'd6);
    chk("slt_exec_func",    8'(bus.o_alu_func), 8'd7);
    chk("slt_exec_src_a",   8'(bus.o_alu_src_a), 8'd1);
    chk("slt_exec_src_b",   8'(bus.o_alu_src_b), 8'd0);
    tick();
    chk("slt_aluwb_state",  8'(bus.o_state), 8'd7);
    chk("slt_aluwb_reg_dst", 8'(bus.o_reg_dst), 8'd1);
    chk("slt_aluwb_rw",     8'(bus.o_reg_write), 8'd1);
    chk("slt_aluwb_m2r",    8'(bus.o_mem_to_reg), 8'd0);
    chk("slt_aluwb_func",   8'(bus.o_alu_func), 8'd0);
    tick();
    chk("slt_done_state",   8'(bus.o_state), 8'd0);

    // R-type sub and and
    drive(OP_RTYPE, FN_SUB, 1'b0, 1'b1);
    tick(); tick();
    chk("sub_exec_func", 8'(bus.o_alu_func), 8'd6);
    tick(); tick();
    drive(OP_RTYPE, FN_AND, 1'b0, 1'b1);
    tick(); tick();
    chk("and_exec_func", 8'(bus.o_alu_func), 8'd0);
    tick(); tick();
    chk("and_done_state", 8'(bus.o_state), 8'd0);

    // beq taken then not taken within the BRANCH cycle
    drive(OP_BEQ, 6'd0, 1'b1, 1'b1);
    tick(); tick();
    chk("beq_state",    8'(bus.o_state), 8'd8);
    chk("beq_pc_en_z1", 8'(bus.o_pc_en), 8'd1);
    chk("beq_pc_src",   8'(bus.o_pc_src), 8'd1);
    chk("beq_func",     8'(bus.o_alu_func), 8'd6);
    drive(OP_BEQ, 6'd0, 1'b0, 1'b1);
    chk("beq_pc_en_z0", 8'(bus.o_pc_en), 8'd0);
    tick();
    chk("beq_done_state", 8'(bus.o_state), 8'd0);

    // sw with ready low for three MEMWR cycles
    drive(OP_SW, 6'd0, 1'b0, 1'b1);
    tick(); tick(); tick();
    for (int i = 0; i < 4; i++) begin
      drive(OP_SW, 6'd0, 1'b0, (i == 3));
      chk("sw_memwr_state", 8'(bus.o_state), 8'd5);
      chk("sw_memwr_mw",    8'(bus.o_mem_write), 8'd1);
      chk("sw_memwr_iord",  8'(bus.o_iord), 8'd1);
      chk("sw_memwr_rw",    8'(bus.o_reg_write), 8'd0);
      tick();
    end
    chk("sw_done_state", 8'(bus.o_state), 8'd0);
    chk("sw_done_mw",    8'(bus.o_mem_write), 8'd0);

    // Illegal opcode pulses in DECODE
    drive(6'b111111, 6'd0, 1'b0, 1'b1);
    tick();
    chk("ill_op_state",   8'(bus.o_state), 8'd1);
    chk("ill_op_pulse",   8'(bus.o_illegal), 8'd1);
    tick();
    chk("ill_op_next",    8'(bus.o_state), 8'd0);
    chk("ill_op_cleared", 8'(bus.o_illegal), 8'd0);

    // Illegal funct pulses in EXEC
    drive(OP_RTYPE, 6'b000111, 1'b0, 1'b1);
    tick();
    chk("ill_fn_decode",  8'(bus.o_illegal), 8'd0);
    tick();
    chk("ill_fn_state",   8'(bus.o_state), 8'd6);
    chk("ill_fn_pulse",   8'(bus.o_illegal), 8'd1);
    chk("ill_fn_func",    8'(bus.o_alu_func), 8'd2);
    tick();
    chk("ill_fn_next",    8'(bus.o_state), 8'd0);

    // addi: 0,1,9,10,0
    drive(OP_ADDI, 6'd0, 1'b0, 1'b1);
    tick(); tick();
    chk("addi_ex_state",  8'(bus.o_state), 8'd9);
    chk("addi_ex_src_b",  8'(bus.o_alu_src_b), 8'd2);
    tick();
    chk("addi_wb_state",  8'(bus.o_state), 8'd10);
    chk("addi_wb_rw",     8'(bus.o_reg_write), 8'd1);
    chk("addi_wb_reg_dst", 8'(bus.o_reg_dst), 8'd0);
    tick();
    chk("addi_done",      8'(bus.o_state), 8'd0);

    // j: 0,1,11,0
    drive(OP_J, 6'd0, 1'b0, 1'b1);
    tick(); tick();
    chk("j_state",  8'(bus.o_state), 8'd11);
    chk("j_pc_src", 8'(bus.o_pc_src), 8'd2);
    chk("j_pc_en",  8'(bus.o_pc_en), 8'd1);
    tick();
    chk("j_done",   8'(bus.o_state), 8'd0);

    // Reset asserted in the middle of MEMRD
    drive(OP_LW, 6'd0, 1'b0, 1'b1);
    tick(); tick(); tick();
    drive(OP_LW, 6'd0, 1'b0, 1'b0);
    chk("rmid_memrd_state", 8'(bus.o_state), 8'd3);
    i_rstn = 1'b0;
    #1;
    chk("rmid_async_state", 8'(bus.o_state), 8'd0);
    chk("rmid_rw",          8'(bus.o_reg_write), 8'd0);
    drive(OP_LW, 6'd0, 1'b0, 1'b1);
    chk("rmid_ir_write",    8'(bus.o_ir_write), 8'd0);
    chk("rmid_pc_en",       8'(bus.o_pc_en), 8'd0);
    tick();
    chk("rmid_held_state",  8'(bus.o_state), 8'd0);
    i_rstn = 1'b1;
    #1;
    chk("rmid_release_state", 8'(bus.o_state), 8'd0);
    chk("rmid_release_irw",   8'(bus.o_ir_write), 8'd1);
    tick();
    chk("rmid_resume_state",  8'(bus.o_state), 8'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mcycle_ctrl.md
MCYCLE_CTRL -- requirements
Module: mcycle_ctrl

Interface
REQ-001 Parameter MEM_HS, default 1: 1 means memory states wait for i_mem_ready; 0 means i_mem_ready is ignored and treated as 1.
REQ-002 i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 i_rstn  input  1  reset, asynchronous assert, active-low.
REQ-004 i_opcode  input  6  instruction[31:26] from instruction register.
REQ-005 i_funct  input  6  instruction[5:0], R-type function field.
REQ-006 i_zero  input  1  ALU result-zero flag.
REQ-007 i_mem_ready  input  1  memory access complete this cycle.
REQ-008 o_alu_func  output  3  drives ALU i_func: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
REQ-009 o_alu_src_a  output  1  0 = PC, 1 = register A.
REQ-010 o_alu_src_b  output  2  00 = reg B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2.
REQ-011 o_pc_src  output  2  00 = ALU result, 01 = ALUOut reg, 10 = jump target.
REQ-012 o_pc_en  output  1  PC write enable.
REQ-013 o_iord, o_ir_write, o_mem_write, o_reg_write, o_reg_dst, o_mem_to_reg  output  1 each  standard multicycle datapath controls.
REQ-014 o_illegal  output  1  one-cycle pulse on undecodable opcode/funct.
REQ-015 o_state  output  4  current state encoding, for debug.

Function
REQ-016 FSM states: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11; codes 12-15 unused.
REQ-017 FETCH: iord=0, alu_src_a=0, alu_src_b=01, alu_func=010, pc_src=00. When ready: ir_write=1 and pc_en=1, go to DECODE. Otherwise hold with ir_write=0 and pc_en=0.
REQ-018 DECODE: alu_src_a=0, alu_src_b=11, alu_func=010 (branch target precompute). Next state by opcode: 100011/101011 to MEMADR, 000000 to EXEC, 000100 to BRANCH, 001000 to ADDIEX, 000010 to JUMP; any other opcode sets o_illegal=1 and goes to FETCH.
REQ-019 MEMADR: alu_src_a=1, alu_src_b=10, alu_func=010. Next is MEMRD for lw, MEMWR for sw.
REQ-020 MEMRD: iord=1. When ready, go to MEMWB; otherwise hold.
REQ-021 MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1, go to FETCH.
REQ-022 MEMWR: iord=1, mem_write=1 held until ready, then FETCH. Exactly one mem_write cycle is asserted while ready=1.
REQ-023 EXEC: alu_src_a=1, alu_src_b=00. funct 100000 gives 010, 100010 gives 110, 100100 gives 000, 100101 gives 001, 101010 gives 111, then ALUWB. Any other funct gives o_illegal=1, alu_func=010, next FETCH.
REQ-024 ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1, go to FETCH.
REQ-025 BRANCH: alu_src_a=1, alu_src_b=00, alu_func=110, pc_src=01, pc_en=i_zero, go to FETCH.
REQ-026 ADDIEX: alu_src_a=1, alu_src_b=10, alu_func=010, go to ADDIWB. ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1, go to FETCH.
REQ-027 JUMP: pc_src=10, pc_en=1, go to FETCH.
REQ-028 Any control not listed for a state is 0. All outputs are decoded combinationally from registered state plus inputs (Mealy only for pc_en in FETCH/BRANCH, ir_write, mem_write, o_illegal).
REQ-029 An unused state code returns to FETCH next cycle with all controls 0.
REQ-030 Instruction latency: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles with ready tied high. Each ready-low cycle adds one.

Reset
REQ-031 While i_rstn=0, state is FETCH asynchronously. All enables/writes (pc_en, ir_write, mem_write, reg_write, o_illegal) are 0 during reset regardless of i_mem_ready.
REQ-032 Reset asserted mid-instruction abandons it; the first cycle after release is FETCH.

Structure
REQ-033 Shared package holds the state encodings, opcode/funct constants and ALU function codes (010, 110, 000, 001, 111), also used by the ALU bench.
REQ-034 One sub-module, alu_dec, maps (alu_op[1:0], i_funct) to o_alu_func combinationally; the FSM drives alu_op 00=add, 01=sub, 10=funct.

Verification
REQ-035 Reset release, ready=1, opcode 100011 -> states 0,1,2,3,4,0; reg_write=1 only in MEMWB; mem_to_reg=1.
REQ-036 Opcode 000000, funct 101010 -> EXEC shows alu_func=111, ALUWB shows reg_dst=1, reg_write=1, 4 cycles total.
REQ-037 Opcode 000100 with i_zero=1 -> pc_en=1, pc_src=01 in BRANCH; repeat with i_zero=0 -> pc_en=0.
REQ-038 Opcode 101011 with ready low for 3 MEMWR cycles -> mem_write held 4 cycles, state leaves on ready, reg_write never set.
REQ-039 Opcode 111111 -> o_illegal pulse for 1 cycle in DECODE, next state FETCH; funct 000111 in EXEC -> same pulse.
REQ-040 i_rstn dropped during MEMRD -> o_state=0 immediately (asynchronously), no reg_write, FETCH resumes after release.
